rm_seq_mul: RTL and testbench



---
 rtl/rm_mul_pkg.sv | 22 ++
 rtl/rm_seq_mul_if.sv | 23 ++
 rtl/rm_mul4_core.sv | 8 +
 rtl/rm_seq_mul.sv | 117 +++++++++++
 tb/tb_rm_seq_mul.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rm_mul_pkg.sv
// Shared constants, FSM state type and the operand magnitude helper
// used by the sequential digit-serial multiplier.
package rm_mul_pkg;
    localparam int DIGIT_W = 4;
    localparam int MAX_W   = 64;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Magnitude of the low w bits of value; the most negative signed value
    // maps to 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value,
                                               input int unsigned      w,
                                               input logic             is_signed);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] r;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        r    = value & mask;
        if (is_signed && r[6'(w-1)])
            r = (~r + 1'b1) & mask;
        return r;
    endfunction
endpackage

// File: rtl/rm_seq_mul_if.sv
// Operand/product handshake bundle for rm_seq_mul.
interface rm_seq_mul_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport slave (
        input  in_valid, in_signed, a, b, out_ready,
        output in_ready, out_valid, product
    );

    modport master (
        output in_valid, in_signed, a, b, out_ready,
        input  in_ready, out_valid, product
    );
endinterface

// File: rtl/rm_mul4_core.sv
// Exact combinational 4x4 unsigned multiplier, 8-bit result.
module rm_mul4_core (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    assign p_o = 8'(a_i) * 8'(b_i);
endmodule

// File: rtl/rm_seq_mul.sv
// Sequential WIDTH x WIDTH multiplier: one 4x4 core walks all digit pairs,
// accumulating shifted partial products; sign is applied once at the end.
module rm_seq_mul
    import rm_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    rm_seq_mul_if.slave bus
);
    localparam int K   = WIDTH / DIGIT_W;
    localparam int NPP = K * K;
    localparam int CW  = (K > 1) ? $clog2(K) : 1;

    if ((WIDTH % DIGIT_W) != 0 || WIDTH < 8 || WIDTH > MAX_W) begin : g_bad_width
        $error("rm_seq_mul: WIDTH must be a multiple of 4 in [8, 64]");
    end

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, prod_q, prod_d;
    logic [CW-1:0]        i_q, i_d, j_q, j_d;

    logic [WIDTH-1:0]     a_sh, b_sh;
    logic [7:0]           pp;
    logic [CW+2:0]        sh_amt;
    logic [2*WIDTH-1:0]   pp_sh, acc_sum;
    logic                 i_last, last;

    // Digit select by shifting, so index width never depends on WIDTH.
    assign a_sh = a_q >> {i_q, 2'b00};
    assign b_sh = b_q >> {j_q, 2'b00};

    rm_mul4_core u_core (
        .a_i (a_sh[3:0]),
        .b_i (b_sh[3:0]),
        .p_o (pp)
    );

    assign sh_amt  = {1'b0, i_q, 2'b00} + {1'b0, j_q, 2'b00};
    assign pp_sh   = (2*WIDTH)'(pp) << sh_amt;
    assign acc_sum = acc_q + pp_sh;
    assign i_last  = (i_q == CW'(K-1));
    assign last    = i_last && (j_q == CW'(K-1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        i_d     = i_q;
        j_d     = j_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = WIDTH'(abs_w(MAX_W'(bus.a), WIDTH, bus.in_signed));
                    b_d     = WIDTH'(abs_w(MAX_W'(bus.b), WIDTH, bus.in_signed));
                    neg_d   = bus.in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                if (i_last) begin
                    i_d = '0;
                    j_d = j_q + CW'(1);
                end else begin
                    i_d = i_q + CW'(1);
                end
                if (last) begin
                    prod_d  = neg_q ? -acc_sum : acc_sum;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            prod_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = prod_q;
endmodule

// File: tb/tb_rm_seq_mul.sv
// Bench for rm_seq_mul at WIDTH 8/12/16/32: directed cases, reset abort,
// backpressure and randomized ops against an arithmetic reference.
module tb_rm_seq_mul;
    logic clk;
    logic rst;

    logic [63:0] a_v [4];
    logic [63:0] b_v [4];
    logic        sg_v [4];
    logic        vld_v [4];
    logic        ordy_v [4];
    logic        irdy_v [4];
    logic        ovld_v [4];
    logic [63:0] prod_v [4];

    int checks = 0;
    int fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 8 : (gi == 1) ? 12 : (gi == 2) ? 16 : 32;
        rm_seq_mul_if #(.WIDTH(W)) bus ();
        rm_seq_mul #(.WIDTH(W)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
        assign bus.in_valid  = vld_v[gi];
        assign bus.in_signed = sg_v[gi];
        assign bus.a         = a_v[gi][W-1:0];
        assign bus.b         = b_v[gi][W-1:0];
        assign bus.out_ready = ordy_v[gi];
        assign irdy_v[gi]    = bus.in_ready;
        assign ovld_v[gi]    = bus.out_valid;
        assign prod_v[gi]    = 64'(bus.product);
    end

    function automatic int wof(input int s);
        return (s == 0) ? 8 : (s == 1) ? 12 : (s == 2) ? 16 : 32;
    endfunction

    function automatic logic [63:0] opmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference: true integer product, reduced modulo 2^(2w).
    function automatic logic [63:0] ref_mul(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic sg);
        longint      sa, sb;
        logic [63:0] p, m;
        m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
        if (sg) begin
            sa = $signed(a << (64-w)) >>> (64-w);
            sb = $signed(b << (64-w)) >>> (64-w);
            p  = sa * sb;
        end else begin
            p = a * b;
        end
        return p & m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance s; starts and ends #1 after a clock edge.
    task automatic do_op(input int s, input logic [63:0] a, input logic [63:0] b,
                         input logic sg, input int hold, output logic [63:0] got);
        int w;
        int npp;
        int n;
        w   = wof(s);
        npp = (w/4) * (w/4);
        a_v[s] = a; b_v[s] = b; sg_v[s] = sg; vld_v[s] = 1'b1;
        chk("in_ready_idle", 64'(irdy_v[s]), 64'd1);
        @(posedge clk); #1;
        vld_v[s] = 1'b0;
        a_v[s] = {$urandom, $urandom}; b_v[s] = {$urandom, $urandom}; sg_v[s] = ~sg;
        chk("in_ready_run", 64'(irdy_v[s]), 64'd0);
        n = 0;
        while (!ovld_v[s] && n < npp + 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(npp));
        got = prod_v[s];
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            chk("hold_product", prod_v[s], got);
            chk("hold_out_valid", 64'(ovld_v[s]), 64'd1);
            chk("hold_in_ready", 64'(irdy_v[s]), 64'd0);
        end
        ordy_v[s] = 1'b1;
        @(posedge clk); #1;
        ordy_v[s] = 1'b0;
        chk("post_hs_out_valid", 64'(ovld_v[s]), 64'd0);
        chk("post_hs_in_ready", 64'(irdy_v[s]), 64'd1);
        chk("post_hs_product", prod_v[s], got);
    endtask

    task automatic dir(input string tag, input int s, input logic [63:0] a,
                       input logic [63:0] b, input logic sg, input int hold,
                       input logic [63:0] exp);
        logic [63:0] got;
        do_op(s, a, b, sg, hold, got);
        chk(tag, got, exp);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] ra, rb;
        logic        rs;
        int          w;
        int          seen;
        for (int s = 0; s < 4; s++) begin
            a_v[s] = '0; b_v[s] = '0; sg_v[s] = 1'b0; vld_v[s] = 1'b0; ordy_v[s] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            chk("rst_in_ready", 64'(irdy_v[s]), 64'd1);
            chk("rst_out_valid", 64'(ovld_v[s]), 64'd0);
            chk("rst_product", prod_v[s], 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        dir("w8_ff_ff_u",   0, 64'hFF,   64'hFF,   1'b0, 0,  64'hFE01);
        dir("w8_80_80_s",   0, 64'h80,   64'h80,   1'b1, 0,  64'h4000);
        dir("w8_80_01_s",   0, 64'h80,   64'h01,   1'b1, 1,  64'hFF80);
        dir("w8_05_fd_s",   0, 64'h05,   64'hFD,   1'b1, 0,  64'hFFF1);
        dir("w8_00_ff_s",   0, 64'h00,   64'hFF,   1'b1, 0,  64'h0);
        dir("w8_ff_00_u",   0, 64'hFF,   64'h00,   1'b0, 0,  64'h0);
        dir("w8_backpress", 0, 64'h12,   64'h34,   1'b0, 10, 64'h3A8);
        dir("w16_7fff_8000_s", 2, 64'h7FFF, 64'h8000, 1'b1, 0, 64'hC000_8000);
        dir("w16_0_x_u",    2, 64'h0,    64'hBEEF, 1'b0, 0,  64'h0);

        // Abort a W16 op five cycles into RUN.
        a_v[2] = 64'h1234; b_v[2] = 64'h5678; sg_v[2] = 1'b0; vld_v[2] = 1'b1;
        @(posedge clk); #1;
        vld_v[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(irdy_v[2]), 64'd1);
        chk("midrst_out_valid", 64'(ovld_v[2]), 64'd0);
        chk("midrst_product", prod_v[2], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (24) begin
            @(posedge clk); #1;
            if (ovld_v[2]) seen++;
        end
        chk("midrst_no_out_valid", 64'(seen), 64'd0);
        dir("w16_ffff_2_u", 2, 64'hFFFF, 64'h0002, 1'b0, 0, 64'h1_FFFE);

        for (int s = 0; s < 4; s++) begin
            w = wof(s);
            for (int k = 0; k < 120; k++) begin
                repeat ($urandom_range(0, 3)) begin
                    ordy_v[s] = 1'($urandom);
                    @(posedge clk); #1;
                end
                ordy_v[s] = 1'b0;
                ra = {$urandom, $urandom} & opmask(w);
                rb = {$urandom, $urandom} & opmask(w);
                if (k == 0) ra = 64'd1 << (w-1);
                if (k == 1) rb = opmask(w);
                rs = 1'($urandom);
                do_op(s, ra, rb, rs, $urandom_range(0, 3), got);
                chk($sformatf("rand_w%0d_%0h_%0h_%0d", w, ra, rb, rs), got, ref_mul(w, ra, rb, rs));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
